// File: rtl/pll_reset_seq.sv
// Reset and lock sequencer for the PLL clock tree: pulses the PLL reset, waits for a stable
// lock, then releases the system reset; re-arms the PLL on lock timeout or lock loss.
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [1:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN
    } state_t;

    localparam logic [15:0] RST_LAST     = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic        locked_m;
    logic        locked_s;
    logic        retry_evt;
    logic        loss_evt;

    // locked is asynchronous to clkin; only locked_s is used beyond this point.
    always_ff @(posedge clkin) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // pre-edge values; with blocking, locked_s would see this edge's locked_m.
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a
        // variable unassigned and no latch is inferred.
        state_nxt = state;
        retry_evt = 1'b0;
        loss_evt  = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = ST_PLL_RST;
                    retry_evt = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s)               state_nxt = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_nxt = ST_PLL_RST;
                    loss_evt  = 1'b1;
                end
            end
            default: state_nxt = ST_PLL_RST;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state     <= ST_PLL_RST;
            cnt       <= 16'd0;
            retry_cnt <= 8'd0;
            loss_cnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            // Every transition restarts the timer; RUN is untimed and keeps it at zero.
            if (state_nxt != state || state == ST_RUN) cnt <= 16'd0;
            else                                       cnt <= cnt + 16'd1;
            if (retry_evt && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
            if (loss_evt && loss_cnt != 8'hFF)   loss_cnt  <= loss_cnt + 8'd1;
        end
    end

    // Outputs decode from the state register only, never from locked.
    assign pll_rst = (state == ST_PLL_RST);
    assign sys_rst = (state != ST_RUN);
    assign ready   = (state == ST_RUN);

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: default-parameter instance for the long timed
// scenarios, short-parameter instance for vector table, saturation and random model runs.
module tb_pll_reset_seq;

    localparam int B_PR = 3;
    localparam int B_TO = 20;
    localparam int B_ST = 10;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, locked_a = 1'b0;
    logic       rst_b = 1'b1, locked_b = 1'b0;
    logic       pll_rst_a, sys_rst_a, ready_a;
    logic       pll_rst_b, sys_rst_b, ready_b;
    logic [7:0] retry_a, loss_a, retry_b, loss_b;

    int n_checks = 0;
    int n_err    = 0;

    always #10 clk = ~clk;

    pll_reset_seq dut_a (
        .clkin(clk), .rst(rst_a), .locked(locked_a),
        .pll_rst(pll_rst_a), .sys_rst(sys_rst_a), .ready(ready_a),
        .retry_cnt(retry_a), .loss_cnt(loss_a)
    );

    pll_reset_seq #(.PLL_RST_CYCLES(B_PR), .LOCK_TIMEOUT(B_TO), .STABLE_CYCLES(B_ST)) dut_b (
        .clkin(clk), .rst(rst_b), .locked(locked_b),
        .pll_rst(pll_rst_b), .sys_rst(sys_rst_b), .ready(ready_b),
        .retry_cnt(retry_b), .loss_cnt(loss_b)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        tick(1);
        rst_a = 1'b0;
    endtask

    task automatic wait_ready_b(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ready_b) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    // Reference model: phases from the spec, elapsed time per phase, locked_s as a 2-deep delay line.
    typedef enum {P_PLLRST, P_WAIT, P_STABLE, P_RUN} phase_e;
    phase_e     m_ph = P_PLLRST;
    int         m_el = 0;
    logic       m_hist[$] = '{1'b0, 1'b0};
    int         m_retry = 0;
    int         m_loss  = 0;

    task automatic model_edge(input logic r, input logic l);
        phase_e nxt;
        logic   ls;
        if (r) begin
            m_ph = P_PLLRST; m_el = 0; m_hist = '{1'b0, 1'b0}; m_retry = 0; m_loss = 0;
        end else begin
            ls  = m_hist[0];
            nxt = m_ph;
            case (m_ph)
                P_PLLRST: if (m_el == B_PR - 1) nxt = P_WAIT;
                P_WAIT: begin
                    if (ls) nxt = P_STABLE;
                    else if (m_el == B_TO - 1) begin
                        nxt = P_PLLRST;
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                    end
                end
                P_STABLE: begin
                    if (!ls) nxt = P_WAIT;
                    else if (m_el == B_ST - 1) nxt = P_RUN;
                end
                P_RUN: begin
                    if (!ls) begin
                        nxt = P_PLLRST;
                        m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                    end
                end
                default: nxt = P_PLLRST;
            endcase
            m_el = (nxt != m_ph) ? 0 : m_el + 1;
            m_ph = nxt;
            void'(m_hist.pop_front());
            m_hist.push_back(l);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       lk;
        int         n;
        logic [2:0] outs;   // {pll_rst, sys_rst, ready}
        logic [7:0] retry;
        logic [7:0] loss;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int sys_low;
        bit ok;
        int hold;
        logic lv, r;
        logic [18:0] exp_v;

        // ---------------- instance A: default parameters ----------------
        reset_a();
        check("a_reset_outs", {pll_rst_a, sys_rst_a, ready_a}, 3'b110);
        check("a_reset_cnts", {retry_a, loss_a}, 16'h0000);

        // Clean lock
        tick(7);
        check("a_pll_rst_7", pll_rst_a, 1'b1);
        tick(1);
        check("a_pll_rst_8", pll_rst_a, 1'b0);
        tick(11);
        locked_a = 1'b1;
        tick(1);
        tick(1025);
        check("a_sys_rst_k1025", sys_rst_a, 1'b1);
        tick(1);
        check("a_run_k1026", {sys_rst_a, ready_a}, 2'b01);
        check("a_clean_cnts", {retry_a, loss_a}, 16'h0000);

        // Lock loss in RUN, then the full sequence repeats
        locked_a = 1'b0;
        tick(1);
        locked_a = 1'b1;
        tick(1);
        check("a_loss_k1", ready_a, 1'b1);
        tick(1);
        check("a_loss_k2", {pll_rst_a, sys_rst_a, ready_a, loss_a}, {3'b110, 8'd1});
        tick(7);
        check("a_repeat_pll_7", pll_rst_a, 1'b1);
        tick(1);
        check("a_repeat_pll_8", pll_rst_a, 1'b0);
        tick(1024);
        check("a_repeat_not_run", ready_a, 1'b0);
        tick(1);
        check("a_repeat_run", {ready_a, retry_a, loss_a}, {1'b1, 8'd0, 8'd1});

        // Stability restart
        locked_a = 1'b0;
        reset_a();
        tick(8);
        locked_a = 1'b1;
        tick(1);
        tick(502);
        locked_a = 1'b0;
        tick(3);
        locked_a = 1'b1;
        tick(1);
        tick(520);
        check("a_restart_no_early_run", ready_a, 1'b0);
        tick(505);
        check("a_restart_k1025", ready_a, 1'b0);
        tick(1);
        check("a_restart_k1026", {ready_a, retry_a}, {1'b1, 8'd0});

        // Timeout retries
        locked_a = 1'b0;
        reset_a();
        sys_low = 0;
        for (int a = 1; a <= 3; a++) begin
            for (int c = 0; c < 8; c++) begin
                tick(1);
                if (!sys_rst_a) sys_low++;
            end
            check("a_to_pll_low", pll_rst_a, 1'b0);
            for (int c = 0; c < 4095; c++) begin
                tick(1);
                if (!sys_rst_a) sys_low++;
            end
            check("a_to_wait_end", {pll_rst_a, retry_a}, {1'b0, 8'(a - 1)});
            tick(1);
            check("a_to_retry", {pll_rst_a, sys_rst_a, retry_a}, {2'b11, 8'(a)});
        end
        check("a_to_sys_low_cycles", sys_low, 0);

        // Mid-operation reset during STABLE with retry_cnt = 2
        reset_a();
        tick(2 * (8 + 4096));
        check("a_mid_retry2", retry_a, 8'd2);
        locked_a = 1'b1;
        tick(8 + 1 + 50);
        rst_a = 1'b1;
        tick(1);
        check("a_mid_reset", {pll_rst_a, sys_rst_a, ready_a, retry_a, loss_a}, {3'b110, 16'h0000});
        rst_a = 1'b0;
        tick(7);
        check("a_mid_pll_7", pll_rst_a, 1'b1);
        tick(1);
        check("a_mid_pll_8", pll_rst_a, 1'b0);

        // ---------------- instance B: short parameters ----------------
        tbl.push_back('{1'b1, 1'b0,  2, 3'b110, 8'd0, 8'd0});
        tbl.push_back('{1'b0, 1'b0,  2, 3'b110, 8'd0, 8'd0});
        tbl.push_back('{1'b0, 1'b0,  1, 3'b010, 8'd0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 19, 3'b010, 8'd0, 8'd0});
        tbl.push_back('{1'b0, 1'b0,  1, 3'b110, 8'd1, 8'd0});
        tbl.push_back('{1'b0, 1'b0,  3, 3'b010, 8'd1, 8'd0});
        tbl.push_back('{1'b0, 1'b1,  2, 3'b010, 8'd1, 8'd0});
        tbl.push_back('{1'b0, 1'b1,  1, 3'b010, 8'd1, 8'd0});
        tbl.push_back('{1'b0, 1'b1,  9, 3'b010, 8'd1, 8'd0});
        tbl.push_back('{1'b0, 1'b1,  1, 3'b001, 8'd1, 8'd0});
        tbl.push_back('{1'b0, 1'b0,  2, 3'b001, 8'd1, 8'd0});
        tbl.push_back('{1'b0, 1'b0,  1, 3'b110, 8'd1, 8'd1});
        tbl.push_back('{1'b1, 1'b0,  1, 3'b110, 8'd0, 8'd0});
        tbl.push_back('{1'b0, 1'b0,  3, 3'b010, 8'd0, 8'd0});
        tbl.push_back('{1'b0, 1'b0, 17, 3'b010, 8'd0, 8'd0});
        tbl.push_back('{1'b0, 1'b1,  3, 3'b010, 8'd0, 8'd0});   // lock and timeout coincide
        tbl.push_back('{1'b0, 1'b1, 10, 3'b001, 8'd0, 8'd0});
        for (int i = 0; i < tbl.size(); i++) begin
            rst_b    = tbl[i].rst;
            locked_b = tbl[i].lk;
            tick(tbl[i].n);
            check($sformatf("b_vec%0d", i),
                  {pll_rst_b, sys_rst_b, ready_b, retry_b, loss_b},
                  {tbl[i].outs, tbl[i].retry, tbl[i].loss});
        end

        // Saturation: 300 lock losses
        rst_b = 1'b1;
        tick(1);
        rst_b    = 1'b0;
        locked_b = 1'b1;
        wait_ready_b(100, ok);
        check("b_sat_first_ready", ok, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            locked_b = 1'b0;
            tick(1);
            locked_b = 1'b1;
            tick(2);
            check($sformatf("b_sat_loss%0d", i), {ready_b, loss_b}, {1'b0, 8'((i < 255) ? i : 255)});
            wait_ready_b(100, ok);
            check("b_sat_ready", ok, 1'b1);
        end

        // Randomized run against the reference model
        hold = 0;
        lv   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                lv   = ($urandom_range(0, 9) < 7);
                hold = $urandom_range(1, 25);
            end
            hold--;
            r        = (i == 0) || ($urandom_range(0, 299) == 0);
            rst_b    = r;
            locked_b = lv;
            tick(1);
            model_edge(r, lv);
            exp_v = {m_ph == P_PLLRST, m_ph != P_RUN, m_ph == P_RUN, 8'(m_retry), 8'(m_loss)};
            check("b_rand", {pll_rst_b, sys_rst_b, ready_b, retry_b, loss_b}, exp_v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset and lock sequencer for the PLL clock tree. It drives the PLL reset input and watches the PLL `locked` output. It releases the system reset only after lock has been continuously stable for a programmable time. It re-arms the PLL automatically on lock timeout or lock loss. It runs on the free-running 50 MHz board clock, the same clock as the PLL reference, so it stays alive while PLL outputs are absent or unstable.

## Interface
- `PLL_RST_CYCLES`, default 8: cycles `pll_rst` is held high on each PLL reset attempt, range 1..65535.
- `LOCK_TIMEOUT`, default 4096: cycles allowed in WAIT_LOCK before a retry, range 1..65535.
- `STABLE_CYCLES`, default 1024: cycles `locked` must stay high continuously before RUN, range 1..65535.
- `clkin` input, 1 bit: 50 MHz board clock, the PLL reference clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `locked` input, 1 bit: PLL lock, asynchronous to `clkin`.
- `pll_rst` output, 1 bit: reset to the PLL, active high.
- `sys_rst` output, 1 bit: system reset, active high, for the consumers of the PLL clocks.
- `ready` output, 1 bit: high only in RUN.
- `retry_cnt` output, 8 bits: count of WAIT_LOCK timeouts, saturating at 255.
- `loss_cnt` output, 8 bits: count of lock losses in RUN, saturating at 255.

Clocking and reset:
- One clock, `clkin`; every register is clocked on its rising edge.
- `rst` is synchronous and active high.

## Operation
- `locked` passes through a 2-flop synchronizer to give `locked_s`, a 2-cycle latency. Only `locked_s` is used after that point.
- There is one 16-bit counter `cnt`. It is cleared to 0 on every state entry, including re-entry. It otherwise increments by 1 each cycle while in a timed state.
- Outputs decode directly from the state register, with no combinational path from `locked`:
  - `pll_rst` = (state == PLL_RST).
  - `sys_rst` = (state != RUN).
  - `ready` = (state == RUN).
- PLL_RST:
  - Exits to WAIT_LOCK when `cnt == PLL_RST_CYCLES-1`.
  - `locked_s` is ignored in this state.
- WAIT_LOCK:
  - If `locked_s` = 1, go to STABLE.
  - Else, if `cnt == LOCK_TIMEOUT-1`, go to PLL_RST and increment `retry_cnt` (saturating).
  - If both conditions hold in the same cycle, lock wins: go to STABLE, with no retry.
- STABLE:
  - If `locked_s` = 0, go to WAIT_LOCK. The WAIT_LOCK timeout restarts from 0.
  - Else, if `cnt == STABLE_CYCLES-1`, go to RUN.
- RUN:
  - If `locked_s` = 0, go to PLL_RST and increment `loss_cnt` (saturating).
  - Otherwise stay in RUN; `cnt` is held at 0.
- Counter rules:
  - Both event counters saturate at 255 and never wrap.
  - Both are cleared only by `rst`.

## Timing
- While `rst` = 1, the following are forced, and hold in the first cycle after release:
  - state = PLL_RST, `cnt` = 0, synchronizer flops = 0.
  - `pll_rst` = 1, `sys_rst` = 1, `ready` = 0.
  - `retry_cnt` = 0, `loss_cnt` = 0.
- After `rst` falls, `pll_rst` stays high for exactly `PLL_RST_CYCLES` further cycles, then falls.
- Lock acquisition: if `locked` is first sampled high at edge k in WAIT_LOCK and stays high:
  - state becomes STABLE at edge k+2;
  - state becomes RUN at edge k+2+`STABLE_CYCLES`;
  - `sys_rst` falls and `ready` rises on that same edge.
- Lock loss in RUN: if `locked` is first sampled low at edge k:
  - state becomes PLL_RST at edge k+2;
  - at that edge `sys_rst` and `pll_rst` rise together and `ready` falls;
  - `loss_cnt` updates on that same edge.
- Timeout: with `locked` low, the WAIT_LOCK→PLL_RST period is exactly `LOCK_TIMEOUT` cycles.
- `rst` asserted mid-operation in any state returns the block to the reset values on the next edge. This also clears both event counters.
- `locked` glitches shorter than 1 cycle may be missed. That is acceptable; only a sampled low counts as a loss.

## Test plan
- **Clean lock.** Release `rst`; raise `locked` 20 cycles later; hold it high.
  - `pll_rst` is high for 8 cycles after release.
  - `sys_rst` falls exactly 1026 cycles after the first edge that samples `locked` high.
  - `retry_cnt` = 0 and `loss_cnt` = 0.
- **Timeout retries.** Hold `locked` low for 3 full attempts.
  - Each attempt is 8 cycles of `pll_rst` followed by 4096 cycles of WAIT_LOCK.
  - `retry_cnt` steps to 1, 2, then 3.
  - `sys_rst` stays 1 throughout.
- **Stability restart.** Raise `locked`; drop it for 3 cycles at STABLE `cnt` = 500; raise it again.
  - The block returns to WAIT_LOCK, then re-enters STABLE.
  - RUN is reached 1026 cycles after the second rising sample.
  - `retry_cnt` is unchanged.
- **Lock loss in RUN.** Reach RUN, then drop `locked` for 1 full cycle.
  - 2 edges later `sys_rst` = 1, `pll_rst` = 1, `ready` = 0, and `loss_cnt` = 1.
  - The full sequence then repeats.
- **Saturation.** Force 300 lock losses.
  - `loss_cnt` reads 255 and does not wrap.
- **Mid-operation reset.** Assert `rst` for 1 cycle during STABLE, with `retry_cnt` = 2.
  - Next edge: all outputs at reset values; `retry_cnt` = 0.
  - The `pll_rst` 8-cycle pulse restarts.
